// File: rtl/sha_job_scheduler.sv
// sha_job_scheduler
//
// Sequences a single sha_block mining instance. Work units (midstate plus
// header block) are accepted into a one-deep buffer. The FSM then copies a
// work unit into the active registers, holds loadState for LOAD_CYCLES,
// enables the search with solveEn, and returns one result per job.
//
// A job ends in one of three ways:
//   - found:     flag seen during SOLVE, goldenNonce captured that cycle
//   - aborted:   job_abort seen during SOLVE
//   - exhausted: MAX_SOLVE_CYCLES solve cycles elapsed
// An abort during LOAD drops the job silently, with no result.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   job_valid/job_ready       job offer handshake (job_ready = buffer empty)
//   job_midstate/job_headdata job payload
//   job_abort                 one-cycle pulse that drops the active job
//   midState/headData         active job towards sha_block (registered)
//   loadState/solveEn         sha_block strobes
//   flag/goldenNonce          sha_block search result
//   result_valid/result_ready result handshake
//   result_found/result_nonce result payload (nonce 0 unless found)
//   busy                      FSM not idle
//
// Build option
//   SHA_SCHED_STATS_EN  adds jobs_done / jobs_found handshake counters.

module sha_job_scheduler #(
  parameter int unsigned             LOAD_CYCLES      = 2,
  parameter int unsigned             TIMEOUT_W        = 32,
  parameter logic [TIMEOUT_W-1:0]    MAX_SOLVE_CYCLES = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [511:0] job_headdata,
  input  logic         job_abort,
  output logic [255:0] midState,
  output logic [511:0] headData,
  output logic         loadState,
  output logic         solveEn,
  input  logic         flag,
  input  logic [31:0]  goldenNonce,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  output logic         busy
`ifdef SHA_SCHED_STATS_EN
  ,
  output logic [31:0]  jobs_done,
  output logic [31:0]  jobs_found
`endif
);

  localparam int unsigned LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [LOAD_W-1:0]    LOAD_LAST  = LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [LOAD_W-1:0]    LOAD_ONE   = LOAD_W'(1'b1);
  localparam logic [TIMEOUT_W-1:0] SOLVE_ONE  = TIMEOUT_W'(1'b1);
  localparam logic [TIMEOUT_W-1:0] SOLVE_LAST = MAX_SOLVE_CYCLES - SOLVE_ONE;
  localparam logic [TIMEOUT_W-1:0] SOLVE_SAT  = {TIMEOUT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SOLVE  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  logic                 buf_full_r;
  logic [255:0]         buf_mid_r;
  logic [511:0]         buf_head_r;
  logic [LOAD_W-1:0]    load_cnt_r;
  logic [TIMEOUT_W-1:0] solve_cnt_r;
  logic                 found_r;
  logic [31:0]          nonce_r;
  logic [255:0]         mid_r;
  logic [511:0]         head_r;

  logic push_s;
  logic pop_s;
  logic handshake_s;

  assign push_s      = job_valid && !buf_full_r;
  // The buffer is consumed exactly when the FSM leaves IDLE.
  assign pop_s       = (state_r == ST_IDLE) && (state_s != ST_IDLE);
  assign handshake_s = (state_r == ST_REPORT) && result_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; exit priority in SOLVE is flag, then abort, then timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (buf_full_r) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (job_abort) begin
          state_s = ST_IDLE;
        end else if (load_cnt_r == LOAD_LAST) begin
          state_s = ST_SOLVE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SOLVE: begin
        if (flag || job_abort || (solve_cnt_r == SOLVE_LAST)) begin
          state_s = ST_REPORT;
        end else begin
          state_s = ST_SOLVE;
        end
      end
      ST_REPORT: begin
        if (result_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // One-deep job buffer; a push wins over a pop so a refill keeps it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_r <= 1'b0;
      buf_mid_r  <= 256'd0;
      buf_head_r <= 512'd0;
    end else if (push_s) begin
      buf_full_r <= 1'b1;
      buf_mid_r  <= job_midstate;
      buf_head_r <= job_headdata;
    end else if (pop_s) begin
      buf_full_r <= 1'b0;
    end else begin
      buf_full_r <= buf_full_r;
    end
  end

  // Active job registers, loaded on IDLE->LOAD and held until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_r  <= 256'd0;
      head_r <= 512'd0;
    end else if (pop_s) begin
      mid_r  <= buf_mid_r;
      head_r <= buf_head_r;
    end else begin
      mid_r  <= mid_r;
      head_r <= head_r;
    end
  end

  // LOAD and SOLVE cycle counters; the solve counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_r  <= {LOAD_W{1'b0}};
      solve_cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_cnt_r  <= {LOAD_W{1'b0}};
          solve_cnt_r <= {TIMEOUT_W{1'b0}};
        end
        ST_LOAD: begin
          load_cnt_r  <= load_cnt_r + LOAD_ONE;
          solve_cnt_r <= {TIMEOUT_W{1'b0}};
        end
        ST_SOLVE: begin
          load_cnt_r <= load_cnt_r;
          if (solve_cnt_r != SOLVE_SAT) begin
            solve_cnt_r <= solve_cnt_r + SOLVE_ONE;
          end else begin
            solve_cnt_r <= solve_cnt_r;
          end
        end
        default: begin
          load_cnt_r  <= load_cnt_r;
          solve_cnt_r <= solve_cnt_r;
        end
      endcase
    end
  end

  // Result capture on SOLVE exit; frozen through REPORT so flag/abort there are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      found_r <= 1'b0;
      nonce_r <= 32'd0;
    end else if (state_r == ST_SOLVE) begin
      if (flag) begin
        found_r <= 1'b1;
        nonce_r <= goldenNonce;
      end else if (job_abort || (solve_cnt_r == SOLVE_LAST)) begin
        found_r <= 1'b0;
        nonce_r <= 32'd0;
      end else begin
        found_r <= found_r;
        nonce_r <= nonce_r;
      end
    end else begin
      found_r <= found_r;
      nonce_r <= nonce_r;
    end
  end

`ifdef SHA_SCHED_STATS_EN
  logic [31:0] jobs_done_r;
  logic [31:0] jobs_found_r;

  // Handshake statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done_r  <= 32'd0;
      jobs_found_r <= 32'd0;
    end else if (handshake_s) begin
      jobs_done_r <= jobs_done_r + 32'd1;
      if (found_r) begin
        jobs_found_r <= jobs_found_r + 32'd1;
      end else begin
        jobs_found_r <= jobs_found_r;
      end
    end else begin
      jobs_done_r  <= jobs_done_r;
      jobs_found_r <= jobs_found_r;
    end
  end

  assign jobs_done  = jobs_done_r;
  assign jobs_found = jobs_found_r;
`else
  logic unused_hs_s;
  assign unused_hs_s = handshake_s;
`endif

  // Strobes are pure decodes of the state flop, so they change only at clock edges.
  assign job_ready    = !buf_full_r;
  assign midState     = mid_r;
  assign headData     = head_r;
  assign loadState    = (state_r == ST_LOAD);
  assign solveEn      = (state_r == ST_SOLVE);
  assign result_valid = (state_r == ST_REPORT);
  assign result_found = found_r;
  assign result_nonce = nonce_r;
  assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sha_job_scheduler.sv
// Self-checking bench for sha_job_scheduler (LOAD_CYCLES=2, MAX_SOLVE_CYCLES=16).
// A table of job scenarios is run through one job task; queueing, abort in
// LOAD and reset mid-SOLVE are exercised as hand-written sequences.

module tb_sha_job_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [511:0] job_headdata;
  logic         job_abort;
  logic [255:0] midState;
  logic [511:0] headData;
  logic         loadState;
  logic         solveEn;
  logic         flag;
  logic [31:0]  goldenNonce;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [31:0]  result_nonce;
  logic         busy;
`ifdef SHA_SCHED_STATS_EN
  logic [31:0]  jobs_done;
  logic [31:0]  jobs_found;
`endif

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int exp_found = 0;

  sha_job_scheduler #(
    .LOAD_CYCLES(2),
    .TIMEOUT_W(32),
    .MAX_SOLVE_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_midstate(job_midstate),
    .job_headdata(job_headdata),
    .job_abort(job_abort),
    .midState(midState),
    .headData(headData),
    .loadState(loadState),
    .solveEn(solveEn),
    .flag(flag),
    .goldenNonce(goldenNonce),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_found(result_found),
    .result_nonce(result_nonce),
    .busy(busy)
`ifdef SHA_SCHED_STATS_EN
    ,
    .jobs_done(jobs_done),
    .jobs_found(jobs_found)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] mid;
    logic [511:0] head;
    int           flag_at;
    int           abort_at;
    logic [31:0]  gn;
    logic         exp_found;
    logic [31:0]  exp_nonce;
    int           exp_solve;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one job from an empty, idle scheduler through to its result handshake.
  task automatic run_job(input vec_t v, input int idx);
    int lc;
    int sc;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, " ready_idle"}, 512'(job_ready), 512'd1);
    job_valid = 1'b1;
    job_midstate = v.mid;
    job_headdata = v.head;
    tick();
    job_valid = 1'b0;
    chk({tag, " ready_full"}, 512'(job_ready), 512'd0);
    tick();
    chk({tag, " mid"}, 512'(midState), 512'(v.mid));
    chk({tag, " head"}, headData, v.head);
    chk({tag, " ready_pop"}, 512'(job_ready), 512'd1);
    lc = 0;
    while (loadState && lc < 20) begin
      chk({tag, " no_solve_in_load"}, 512'(solveEn), 512'd0);
      lc++;
      tick();
    end
    chk({tag, " load_cycles"}, 512'(lc), 512'd2);
    sc = 0;
    while (solveEn && sc < 100) begin
      if (sc == v.flag_at) begin
        flag = 1'b1;
        goldenNonce = v.gn;
      end
      if (sc == v.abort_at) begin
        job_abort = 1'b1;
      end
      tick();
      flag = 1'b0;
      job_abort = 1'b0;
      goldenNonce = 32'hFFFF_0000;
      sc++;
    end
    chk({tag, " solve_cycles"}, 512'(sc), 512'(v.exp_solve));
    chk({tag, " valid"}, 512'(result_valid), 512'd1);
    chk({tag, " found"}, 512'(result_found), 512'(v.exp_found));
    chk({tag, " nonce"}, 512'(result_nonce), 512'(v.exp_nonce));
    // flag and abort in REPORT must not disturb the held result
    flag = 1'b1;
    job_abort = 1'b1;
    goldenNonce = 32'h0BAD_0BAD;
    tick();
    flag = 1'b0;
    job_abort = 1'b0;
    tick();
    chk({tag, " valid_held"}, 512'(result_valid), 512'd1);
    chk({tag, " found_held"}, 512'(result_found), 512'(v.exp_found));
    chk({tag, " nonce_held"}, 512'(result_nonce), 512'(v.exp_nonce));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_done++;
    if (v.exp_found) exp_found++;
    chk({tag, " valid_drop"}, 512'(result_valid), 512'd0);
    chk({tag, " idle"}, 512'(busy), 512'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_midstate = 256'd0;
    job_headdata = 512'd0;
    job_abort = 1'b0;
    flag = 1'b0;
    goldenNonce = 32'd0;
    result_ready = 1'b0;

    vecs[0] = '{256'h1, 512'h2, 10, -1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 11};
    vecs[1] = '{{8{32'hA5A5_0001}}, {16{32'h5A5A_0002}}, -1, -1, 32'h0, 1'b0, 32'h0, 16};
    vecs[2] = '{256'h33, 512'h44, -1, 5, 32'h0, 1'b0, 32'h0, 6};
    vecs[3] = '{256'h55, 512'h66, 3, 3, 32'h1234_5678, 1'b1, 32'h1234_5678, 4};
    vecs[4] = '{256'h77, 512'h88, 0, -1, 32'h0000_0001, 1'b1, 32'h0000_0001, 1};
    vecs[5] = '{256'h99, 512'hAA, 15, -1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 16};

    tick();
    tick();
    chk("rst job_ready", 512'(job_ready), 512'd1);
    chk("rst loadState", 512'(loadState), 512'd0);
    chk("rst solveEn", 512'(solveEn), 512'd0);
    chk("rst result_valid", 512'(result_valid), 512'd0);
    chk("rst result_found", 512'(result_found), 512'd0);
    chk("rst result_nonce", 512'(result_nonce), 512'd0);
    chk("rst busy", 512'(busy), 512'd0);
    chk("rst midState", 512'(midState), 512'd0);
    chk("rst headData", headData, 512'd0);
`ifdef SHA_SCHED_STATS_EN
    chk("rst jobs_done", 512'(jobs_done), 512'd0);
    chk("rst jobs_found", 512'(jobs_found), 512'd0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i], i);
      tick();
    end

    // Queueing: job B offered while A is solving, loaded after A's handshake.
    job_valid = 1'b1;
    job_midstate = 256'hA0A0;
    job_headdata = 512'hA1A1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("q solve_a", 512'(solveEn), 512'd1);
    job_valid = 1'b1;
    job_midstate = 256'hB0B0;
    job_headdata = 512'hB1B1;
    tick();
    job_valid = 1'b0;
    chk("q ready_drop", 512'(job_ready), 512'd0);
    chk("q mid_a_held", 512'(midState), 512'h0A0A0);
    flag = 1'b1;
    goldenNonce = 32'h0000_0A0A;
    tick();
    flag = 1'b0;
    chk("q valid_a", 512'(result_valid), 512'd1);
    chk("q nonce_a", 512'(result_nonce), 512'h0A0A);
    chk("q ready_report", 512'(job_ready), 512'd0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_done++;
    exp_found++;
    chk("q idle_gap", 512'(busy), 512'd0);
    chk("q ready_gap", 512'(job_ready), 512'd0);
    tick();
    chk("q load_b", 512'(loadState), 512'd1);
    chk("q mid_b", 512'(midState), 512'hB0B0);
    chk("q head_b", headData, 512'hB1B1);
    chk("q ready_back", 512'(job_ready), 512'd1);

    // Abort during LOAD: back to IDLE with no result.
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    chk("la busy", 512'(busy), 512'd0);
    chk("la loadState", 512'(loadState), 512'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("la no_result", 512'(result_valid | busy), 512'd0);
    end
    chk("la ready", 512'(job_ready), 512'd1);

`ifdef SHA_SCHED_STATS_EN
    chk("st jobs_done", 512'(jobs_done), 512'(exp_done));
    chk("st jobs_found", 512'(jobs_found), 512'(exp_found));
`endif

    // Reset mid-SOLVE with a queued job discards both.
    job_valid = 1'b1;
    job_midstate = 256'hC0C0;
    job_headdata = 512'hC1C1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rs solving", 512'(solveEn), 512'd1);
    job_valid = 1'b1;
    job_midstate = 256'hD0D0;
    job_headdata = 512'hD1D1;
    tick();
    job_valid = 1'b0;
    chk("rs queued", 512'(job_ready), 512'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs busy", 512'(busy), 512'd0);
    chk("rs solveEn", 512'(solveEn), 512'd0);
    chk("rs job_ready", 512'(job_ready), 512'd1);
    chk("rs result_valid", 512'(result_valid), 512'd0);
    chk("rs midState", 512'(midState), 512'd0);
`ifdef SHA_SCHED_STATS_EN
    chk("rs jobs_done", 512'(jobs_done), 512'd0);
    chk("rs jobs_found", 512'(jobs_found), 512'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rs stays_idle", 512'(busy | result_valid | loadState), 512'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_job_scheduler.md
Name: sha_job_scheduler

Overview:
- Sequences one sha_block mining instance: accepts work units (midState + header), loads them, runs the search and returns one result per job (golden nonce found, timeout, or aborted).
- One-deep job buffer, so the next job can be queued while the current one is solving.
- Sits between the host/UART job interface and sha_block.
- Drives sha_block's midState, headData, loadState and solveEn; monitors its flag and goldenNonce.

Parameters:
- LOAD_CYCLES, 2, cycles loadState is held high per job (≥1).
- TIMEOUT_W, 32, width of the solve-cycle counter.
- MAX_SOLVE_CYCLES, 32'hFFFF_FFFF, solve cycles before a job is declared exhausted (≥1, fits TIMEOUT_W).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  buffer slot free
- job_midstate  in  256  job midstate
- job_headdata  in  512  job header block
- job_abort  in  1  one-cycle pulse: drop the active job
- midState  out  256  to sha_block
- headData  out  512  to sha_block
- loadState  out  1  to sha_block
- solveEn  out  1  to sha_block
- flag  in  1  from sha_block: nonce found
- goldenNonce  in  32  from sha_block
- result_valid  out  1  result available
- result_ready  in  1  result consumed
- result_found  out  1  1 = nonce found, 0 = exhausted/aborted
- result_nonce  out  32  golden nonce when found, else 0
- busy  out  1  state ≠ IDLE

Behaviour:
Job buffer
- Fields: buf_full, buf_mid, buf_head.
- job_ready = ~buf_full.
- A job is accepted on a cycle where job_valid && job_ready; it is written next edge.
- The buffer pops when the FSM leaves IDLE. Simultaneous pop and push in the same cycle is legal: the buffer stays full with the new data.

Active registers
- midState and headData are registered and copied from the buffer on the IDLE→LOAD edge.
- They are held constant until the next load.

FSM states: IDLE, LOAD, SOLVE, REPORT.
- IDLE: all strobes low. If buf_full → LOAD, copy the job, load_cnt=0.
- LOAD: loadState=1, solveEn=0. load_cnt increments each cycle; at load_cnt==LOAD_CYCLES-1 → SOLVE, solve_cnt=0. job_abort in LOAD → IDLE, no result.
- SOLVE: loadState=0, solveEn=1. solve_cnt increments each cycle and saturates. Exit priority:
  1. flag=1: capture goldenNonce that cycle, result_found=1 → REPORT.
  2. job_abort=1: result_found=0, nonce=0 → REPORT.
  3. solve_cnt==MAX_SOLVE_CYCLES-1: result_found=0, nonce=0 → REPORT.
- REPORT: result_valid=1, solveEn=0, loadState=0. result_found and result_nonce are stable while valid. On result_valid && result_ready → IDLE next cycle. A further job_abort or flag in REPORT is ignored.

Other rules
- flag and job_abort on the same cycle: flag wins, and the found result is reported.
- Latency: job accepted at edge N → LOAD at N+1 (if IDLE) → first solveEn at N+1+LOAD_CYCLES.
- Back-to-back jobs: minimum one IDLE cycle between REPORT and LOAD.

Reset (synchronous, rst=1)
- State IDLE; buf_full=0; load_cnt, solve_cnt, result_found, result_nonce = 0.
- All outputs 0 except job_ready=1.
- midState and headData are reset to 0.
- Reset mid-LOAD or mid-SOLVE discards both jobs, with no result.

Optional Feature:
SHA_SCHED_STATS_EN
- Defined: adds outputs jobs_done[31:0] and jobs_found[31:0], both reset to 0.
  - jobs_done increments on each result handshake.
  - jobs_found increments on handshakes with result_found=1.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic find (LOAD_CYCLES=2): push job mid=256'h1, head=512'h2 → loadState high 2 cycles, then solveEn. Force flag=1, goldenNonce=32'hDEADBEEF at solve cycle 10 → result_valid, found=1, nonce=DEADBEEF; held until result_ready.
- Timeout (MAX_SOLVE_CYCLES=16, flag never set) → solveEn high exactly 16 cycles, then result found=0, nonce=0.
- Queueing: push job A, then job B during A's SOLVE → job_ready drops. After A's result handshake, B is loaded with mid/head equal to B's values; job_ready returns high on that same transition.
- Abort vs flag: job_abort alone in SOLVE → found=0 result. job_abort and flag (nonce 32'h12345678) on the same cycle → found=1, nonce=12345678. Abort during LOAD → back to IDLE, no result_valid.
- Reset mid-SOLVE with a queued job → next cycle IDLE, buf empty, solveEn=0, job_ready=1, no result emitted.
- With SHA_SCHED_STATS_EN: 3 jobs (found, timeout, found) → jobs_done=3, jobs_found=2; rst clears both.
